// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 timing constants shared by the scan driver and its axis counters.
package vga_pkg;
    localparam int H_VISIBLE    = 640;
    localparam int H_FRONT      = 16;
    localparam int H_SYNC       = 96;
    localparam int H_BACK       = 48;
    localparam int H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int V_VISIBLE    = 480;
    localparam int V_FRONT      = 10;
    localparam int V_SYNC       = 2;
    localparam int V_BACK       = 33;
    localparam int V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;
    localparam int COORD_W      = 11;
endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: enabled 0..TOTAL-1 wrap counter with an active-low sync-window decode.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int TOTAL      = H_TOTAL,
    parameter int SYNC_START = H_SYNC_START,
    parameter int SYNC_END   = H_SYNC_END,
    parameter int W          = $clog2(TOTAL)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         wrap,
    output logic         sync_n
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        wrap   = en && (cnt_q == W'(TOTAL - 1));
        cnt_d  = wrap ? '0 : (en ? cnt_q + W'(1) : cnt_q);
        sync_n = !((cnt_q >= W'(SYNC_START)) && (cnt_q <= W'(SYNC_END)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/vga_scan_driver.sv
// vga_scan_driver: pixel-clock divider, H/V scan counters and a one-pixel registered,
// blanked output stage to the DAC; geometry defaults to vga_pkg timing.
module vga_scan_driver
    import vga_pkg::*;
#(
    parameter int H_VIS = H_VISIBLE,
    parameter int H_FP  = H_FRONT,
    parameter int H_SW  = H_SYNC,
    parameter int H_BP  = H_BACK,
    parameter int V_VIS = V_VISIBLE,
    parameter int V_FP  = V_FRONT,
    parameter int V_SW  = V_SYNC,
    parameter int V_BP  = V_BACK
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic [7:0]         Red_in,
    input  logic [7:0]         Green_in,
    input  logic [7:0]         Blue_in,
    output logic [COORD_W-1:0] DrawX,
    output logic [COORD_W-1:0] DrawY,
    output logic [7:0]         VGA_R,
    output logic [7:0]         VGA_G,
    output logic [7:0]         VGA_B,
    output logic               VGA_CLK,
    output logic               VGA_HS,
    output logic               VGA_VS,
    output logic               VGA_BLANK_N,
    output logic               Frame_Tick
);
    localparam int H_TOT = H_VIS + H_FP + H_SW + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SW + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          h_wrap, v_wrap, h_sync_n, v_sync_n, vis_raw;
    logic          phase_q, phase_d, vga_clk_q, vga_clk_d;
    logic          hs_q, hs_d, vs_q, vs_d, vis_q, vis_d, tick_q, tick_d;
    logic [23:0]   rgb_q, rgb_d;

    vga_axis_counter #(
        .TOTAL(H_TOT), .SYNC_START(H_VIS + H_FP), .SYNC_END(H_VIS + H_FP + H_SW - 1), .W(HW)
    ) u_h (
        .clk(Clk), .rst_n(Reset_n), .en(phase_q), .cnt(h_cnt), .wrap(h_wrap), .sync_n(h_sync_n)
    );

    vga_axis_counter #(
        .TOTAL(V_TOT), .SYNC_START(V_VIS + V_FP), .SYNC_END(V_VIS + V_FP + V_SW - 1), .W(VW)
    ) u_v (
        .clk(Clk), .rst_n(Reset_n), .en(h_wrap), .cnt(v_cnt), .wrap(v_wrap), .sync_n(v_sync_n)
    );

    // phase_q high marks the pix_ce cycle; VGA_CLK lags it so it is low during pix_ce
    always_comb begin
        vis_raw   = (h_cnt < HW'(H_VIS)) && (v_cnt < VW'(V_VIS));
        phase_d   = !phase_q;
        vga_clk_d = phase_q;
        hs_d      = phase_q ? h_sync_n : hs_q;
        vs_d      = phase_q ? v_sync_n : vs_q;
        vis_d     = phase_q ? vis_raw : vis_q;
        rgb_d     = phase_q ? (vis_raw ? {Red_in, Green_in, Blue_in} : 24'd0) : rgb_q;
        tick_d    = v_wrap;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            phase_q   <= 1'b0;
            vga_clk_q <= 1'b0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            vis_q     <= 1'b0;
            rgb_q     <= '0;
            tick_q    <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            vga_clk_q <= vga_clk_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            vis_q     <= vis_d;
            rgb_q     <= rgb_d;
            tick_q    <= tick_d;
        end
    end

    assign DrawX       = COORD_W'(h_cnt);
    assign DrawY       = COORD_W'(v_cnt);
    assign {VGA_R, VGA_G, VGA_B} = rgb_q;
    assign VGA_CLK     = vga_clk_q;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK_N = vis_q;
    assign Frame_Tick  = tick_q;
endmodule

// File: tb/tb_vga_scan_driver.sv
// tb_vga_scan_driver: full-size and shrunken-geometry instances driven with random colours and
// random mid-frame resets, checked every Clk against a pixel-index arithmetic model.
module tb_vga_scan_driver;
    typedef struct {int hv, hf, hs, hb, vv, vf, vs, vb;} geo_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  red, green, blue;
    logic [10:0] dx [2];
    logic [10:0] dy [2];
    logic [7:0]  vr [2];
    logic [7:0]  vg [2];
    logic [7:0]  vb [2];
    logic        vclk [2];
    logic        hs [2];
    logic        vs [2];
    logic        blank_n [2];
    logic        tick [2];
    geo_t        geo [2];
    int          n;
    logic [23:0] cap;
    int          checks = 0;
    int          failures = 0;

    always #10 clk = ~clk;

    vga_scan_driver u_full (
        .Clk(clk), .Reset_n(rst_n), .Red_in(red), .Green_in(green), .Blue_in(blue),
        .DrawX(dx[0]), .DrawY(dy[0]), .VGA_R(vr[0]), .VGA_G(vg[0]), .VGA_B(vb[0]),
        .VGA_CLK(vclk[0]), .VGA_HS(hs[0]), .VGA_VS(vs[0]), .VGA_BLANK_N(blank_n[0]),
        .Frame_Tick(tick[0])
    );

    vga_scan_driver #(
        .H_VIS(8), .H_FP(2), .H_SW(3), .H_BP(3), .V_VIS(4), .V_FP(1), .V_SW(2), .V_BP(1)
    ) u_small (
        .Clk(clk), .Reset_n(rst_n), .Red_in(red), .Green_in(green), .Blue_in(blue),
        .DrawX(dx[1]), .DrawY(dy[1]), .VGA_R(vr[1]), .VGA_G(vg[1]), .VGA_B(vb[1]),
        .VGA_CLK(vclk[1]), .VGA_HS(hs[1]), .VGA_VS(vs[1]), .VGA_BLANK_N(blank_n[1]),
        .Frame_Tick(tick[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            if (failures <= 20) $display("FAIL %s n=%0d got=%0d exp=%0d", tag, n, got, exp);
        end
    endtask

    // n rising edges since reset release; pixel p = n/2 is on DrawX/Y, pixel p-1 is on the outputs
    task automatic check_all(input int k);
        geo_t g = geo[k];
        int ht = g.hv + g.hf + g.hs + g.hb;
        int vt = g.vv + g.vf + g.vs + g.vb;
        int p = n / 2;
        int q = p - 1;
        int hq = q % ht;
        int vq = (q / ht) % vt;
        bit vis = (p > 0) && (hq < g.hv) && (vq < g.vv);
        bit e_hs = (p == 0) || !(hq >= g.hv + g.hf && hq < g.hv + g.hf + g.hs);
        bit e_vs = (p == 0) || !(vq >= g.vv + g.vf && vq < g.vv + g.vf + g.vs);
        logic [23:0] rgb = vis ? cap : 24'd0;
        check($sformatf("%0d:drawx", k), 32'(dx[k]), 32'(p % ht));
        check($sformatf("%0d:drawy", k), 32'(dy[k]), 32'((p / ht) % vt));
        check($sformatf("%0d:vga_clk", k), 32'(vclk[k]), 32'(n > 0 && n % 2 == 0));
        check($sformatf("%0d:hs", k), 32'(hs[k]), 32'(e_hs));
        check($sformatf("%0d:vs", k), 32'(vs[k]), 32'(e_vs));
        check($sformatf("%0d:blank_n", k), 32'(blank_n[k]), 32'(vis));
        check($sformatf("%0d:rgb", k), 32'({vr[k], vg[k], vb[k]}), 32'(rgb));
        check($sformatf("%0d:tick", k), 32'(tick[k]), 32'(p > 0 && n % 2 == 0 && p % (ht * vt) == 0));
    endtask

    initial begin
        geo[0] = '{640, 16, 96, 48, 480, 10, 2, 33};
        geo[1] = '{8, 2, 3, 3, 4, 1, 2, 1};
        rst_n = 1'b0;
        {red, green, blue} = 24'hFFFFFF;
        n = 0;
        cap = '0;
        repeat (3) @(negedge clk);
        check_all(0);
        check_all(1);
        rst_n = 1'b1;
        for (int c = 0; c < 20000; c++) begin
            @(posedge clk);
            n++;
            if (n % 2 == 0) cap = {red, green, blue};
            @(negedge clk);
            check_all(0);
            check_all(1);
            {red, green, blue} = (c < 3000 && c % 700 < 350) ? 24'hFFFFFF : 24'($urandom);
            if (c == 5001 || (c > 6000 && $urandom_range(0, 2999) == 0)) begin
                #3 rst_n = 1'b0;
                n = 0;
                #1 check_all(0);
                check_all(1);
                repeat (3) @(posedge clk);
                @(negedge clk);
                check_all(0);
                check_all(1);
                rst_n = 1'b1;
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
